// File: rtl/audio_pkg.sv
// Shared audio types for the bus logic, frame FIFO and I2S transmitter.
// Holds the sample width, the stereo frame layout and the drain FSM states.
package audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } audio_frame_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        HOLD = 2'd2
    } drain_state_t;

endpackage

// File: rtl/audio_fifo_mem.sv
// Frame storage: synchronous write, registered read with enable, no control logic.
// Read data appears one edge after rd_en and holds until the next enabled read.
module audio_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 48,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_frame_fifo.sv
// Stereo frame FIFO feeding i2s_master; 2 cycles from write strobe to out_write pulse.
// Writes while full are dropped (sticky overflow); drain pauses while out_full_i, max 1 frame / 3 cycles.
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
    parameter int LOW_WATER = 4,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [SAMPLE_W-1:0] in_l,
    input  logic [SAMPLE_W-1:0] in_r,
    input  logic                in_valid,
    output logic                in_full,
    input  logic                clear_i,
    output logic [SAMPLE_W-1:0] out_l,
    output logic [SAMPLE_W-1:0] out_r,
    output logic                out_write,
    input  logic                out_full_i,
    output logic [CW-1:0]       level_o,
    output logic                low_irq_o,
    output logic                overflow_o
);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  overflow;
    logic [2*SAMPLE_W-1:0] rd_dat;
    drain_state_t          state;
    drain_state_t          state_nxt;

    assign full = (count == CW'(DEPTH));
    // Full is judged on the pre-edge count, so a same-cycle pop never frees room for this write.
    assign push = in_valid && !full && !clear_i;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        out_write = 1'b0;
        case (state)
            IDLE: begin
                if (!clear_i && (count != '0) && !out_full_i) begin
                    pop       = 1'b1;
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                out_write = 1'b1;
                state_nxt = HOLD;
            end
            // out_full_i from i2s_master lags the pulse by a cycle; ignore it here.
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear_i) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    audio_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (2 * SAMPLE_W)
    ) u_mem (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_dat  ({in_l, in_r}),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_dat  (rd_dat)
    );

    assign out_l      = rd_dat[2*SAMPLE_W-1:SAMPLE_W];
    assign out_r      = rd_dat[SAMPLE_W-1:0];
    assign in_full    = full;
    assign level_o    = count;
    assign low_irq_o  = (count <= CW'(LOW_WATER));
    assign overflow_o = overflow;

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Bench for audio_frame_fifo: vector table, directed corner sequences and random traffic
// checked every cycle against a queue-based frame model.
module tb_audio_frame_fifo;

    localparam int DEPTH = 16;
    localparam int SW    = 24;
    localparam int LW    = 4;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic [SW-1:0] in_l = '0;
    logic [SW-1:0] in_r = '0;
    logic          in_valid = 1'b0;
    logic          in_full;
    logic          clear_i = 1'b0;
    logic [SW-1:0] out_l;
    logic [SW-1:0] out_r;
    logic          out_write;
    logic          out_full_i = 1'b0;
    logic [4:0]    level_o;
    logic          low_irq_o;
    logic          overflow_o;

    always #5 clk_i = ~clk_i;

    audio_frame_fifo #(
        .DEPTH     (DEPTH),
        .SAMPLE_W  (SW),
        .LOW_WATER (LW)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .in_l       (in_l),
        .in_r       (in_r),
        .in_valid   (in_valid),
        .in_full    (in_full),
        .clear_i    (clear_i),
        .out_l      (out_l),
        .out_r      (out_r),
        .out_write  (out_write),
        .out_full_i (out_full_i),
        .level_o    (level_o),
        .low_irq_o  (low_irq_o),
        .overflow_o (overflow_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: queue of frames, sticky overflow, and a cooldown counter after each pop.
    bit [2*SW-1:0] mq[$];
    bit            m_ovf;
    int            m_busy;
    bit            m_write;
    bit [SW-1:0]   m_l;
    bit [SW-1:0]   m_r;

    typedef struct {
        bit          vld;
        bit [SW-1:0] l;
        bit [SW-1:0] r;
        bit          full;
        bit          clr;
        int          lvl;
        bit          wr;
        bit          ovf;
        bit          low;
        bit [SW-1:0] el;
        bit [SW-1:0] er;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_busy  = 0;
        m_write = 1'b0;
        m_l     = '0;
        m_r     = '0;
    endtask

    task automatic model_edge();
        bit pop;
        int sz;
        sz = mq.size();
        if (clear_i) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_busy  = 0;
            m_write = 1'b0;
            return;
        end
        pop = (m_busy == 0) && (sz > 0) && !out_full_i;
        if (pop) {m_l, m_r} = mq[0];
        if (in_valid) begin
            if (sz == DEPTH) m_ovf = 1'b1;
            else mq.push_back({in_l, in_r});
        end
        if (pop) void'(mq.pop_front());
        m_busy  = pop ? 2 : ((m_busy > 0) ? m_busy - 1 : 0);
        m_write = pop;
    endtask

    task automatic compare_model();
        chk("level",     48'(level_o),    48'(mq.size()));
        chk("in_full",   48'(in_full),    48'(mq.size() == DEPTH));
        chk("low_irq",   48'(low_irq_o),  48'(mq.size() <= LW));
        chk("overflow",  48'(overflow_o), 48'(m_ovf));
        chk("out_write", 48'(out_write),  48'(m_write));
        chk("out_l",     48'(out_l),      48'(m_l));
        chk("out_r",     48'(out_r),      48'(m_r));
    endtask

    task automatic step();
        @(posedge clk_i);
        cyc++;
        model_edge();
        #1;
        compare_model();
    endtask

    function automatic vec_t mk(bit vld, bit [SW-1:0] l, bit [SW-1:0] r, bit full, bit clr,
                                int lvl, bit wr, bit ovf, bit low, bit [SW-1:0] el, bit [SW-1:0] er);
        vec_t v;
        v.vld = vld; v.l = l; v.r = r; v.full = full; v.clr = clr;
        v.lvl = lvl; v.wr = wr; v.ovf = ovf; v.low = low; v.el = el; v.er = er;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int last;
        int written;
        int guard;

        //           vld  l            r            full clr lvl wr ovf low el           er
        tbl[0]  = mk(1, 24'h000001, 24'h000101, 1, 0, 1, 0, 0, 1, 24'h0,      24'h0);
        tbl[1]  = mk(1, 24'h000002, 24'h000102, 1, 0, 2, 0, 0, 1, 24'h0,      24'h0);
        tbl[2]  = mk(1, 24'h000003, 24'h000103, 1, 0, 3, 0, 0, 1, 24'h0,      24'h0);
        tbl[3]  = mk(1, 24'h000004, 24'h000104, 1, 0, 4, 0, 0, 1, 24'h0,      24'h0);
        tbl[4]  = mk(1, 24'h000005, 24'h000105, 1, 0, 5, 0, 0, 0, 24'h0,      24'h0);
        tbl[5]  = mk(1, 24'h000006, 24'h000106, 1, 0, 6, 0, 0, 0, 24'h0,      24'h0);
        tbl[6]  = mk(1, 24'h000007, 24'h000107, 1, 1, 0, 0, 0, 1, 24'h0,      24'h0);
        tbl[7]  = mk(1, 24'h123456, 24'hABCDEF, 0, 0, 1, 0, 0, 1, 24'h0,      24'h0);
        tbl[8]  = mk(0, 24'h0,      24'h0,      0, 0, 0, 1, 0, 1, 24'h123456, 24'hABCDEF);
        tbl[9]  = mk(0, 24'h0,      24'h0,      0, 0, 0, 0, 0, 1, 24'h123456, 24'hABCDEF);
        tbl[10] = mk(0, 24'h0,      24'h0,      0, 0, 0, 0, 0, 1, 24'h123456, 24'hABCDEF);

        // Reset state
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        compare_model();
        chk("rst_low_irq", 48'(low_irq_o), 48'd1);
        chk("rst_level",   48'(level_o),   48'd0);
        rstn_i = 1'b1;

        // Vector table: level sweep across LOW_WATER, clear, first-frame latency
        for (int i = 0; i < 11; i++) begin
            in_valid   = tbl[i].vld;
            in_l       = tbl[i].l;
            in_r       = tbl[i].r;
            out_full_i = tbl[i].full;
            clear_i    = tbl[i].clr;
            step();
            chk("tbl_level",     48'(level_o),    48'(tbl[i].lvl));
            chk("tbl_out_write", 48'(out_write),  48'(tbl[i].wr));
            chk("tbl_overflow",  48'(overflow_o), 48'(tbl[i].ovf));
            chk("tbl_low_irq",   48'(low_irq_o),  48'(tbl[i].low));
            chk("tbl_out_l",     48'(out_l),      48'(tbl[i].el));
            chk("tbl_out_r",     48'(out_r),      48'(tbl[i].er));
        end
        in_valid = 1'b0;
        clear_i  = 1'b0;

        // Fill to full, overflow, drain in order, clear on entry to PUSH
        out_full_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_l = 24'h000100 + 24'(i);
            in_r = 24'h000200 + 24'(i);
            step();
        end
        chk("full_after_16", 48'(in_full),    48'd1);
        chk("ovf_before_17", 48'(overflow_o), 48'd0);
        in_l = 24'hDEAD00;
        step();
        chk("ovf_after_17",   48'(overflow_o), 48'd1);
        chk("level_after_17", 48'(level_o),    48'd16);
        out_full_i = 1'b0;
        step();
        chk("pop_no_room_level", 48'(level_o),   48'd15);
        chk("pop_no_room_write", 48'(out_write), 48'd1);
        chk("drain_first_data",  48'(out_l),     48'h100);
        in_valid = 1'b0;
        last = cyc;
        k = 1;
        guard = 0;
        while (!(mq.size() == 8 && m_busy == 0) && guard < 200) begin
            step();
            guard++;
            if (out_write) begin
                chk("drain_data_l", 48'(out_l), 48'(24'h000100 + 24'(k)));
                chk("drain_data_r", 48'(out_r), 48'(24'h000200 + 24'(k)));
                chk("drain_spacing", 48'(cyc - last), 48'd3);
                last = cyc;
                k++;
            end
        end
        chk("drain_level8", 48'(level_o), 48'd8);
        chk("drain_ovf_held", 48'(overflow_o), 48'd1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr_out_write", 48'(out_write),  48'd0);
        chk("clr_level",     48'(level_o),    48'd0);
        chk("clr_overflow",  48'(overflow_o), 48'd0);
        chk("clr_low_irq",   48'(low_irq_o),  48'd1);
        chk("clr_keeps_l",   48'(out_l),      48'(24'h000100 + 24'(k - 1)));
        step();
        chk("clr_no_late_pulse", 48'(out_write), 48'd0);
        step();

        // Write coincident with pop at level 5, across pointer wrap
        out_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_l = 24'h300000 + 24'(i);
            in_r = 24'h310000 + 24'(i);
            step();
        end
        in_valid   = 1'b0;
        out_full_i = 1'b0;
        written = 0;
        guard = 0;
        while (written < 40 && guard < 400) begin
            in_valid = (m_busy == 0) && (mq.size() > 0);
            in_l = 24'h400000 + 24'(written);
            in_r = 24'h410000 + 24'(written);
            step();
            guard++;
            if (in_valid) begin
                written++;
                chk("wrap_level5", 48'(level_o), 48'd5);
            end
        end
        chk("wrap_done", 48'(written), 48'd40);
        in_valid = 1'b0;
        repeat (20) step();
        chk("wrap_drained_l", 48'(out_l), 48'h400027);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_valid   = ($urandom_range(0, 99) < 45);
            out_full_i = ($urandom_range(0, 99) < 30);
            clear_i    = ($urandom_range(0, 99) < 2);
            in_l       = 24'($urandom);
            in_r       = 24'($urandom);
            step();
        end
        in_valid   = 1'b0;
        clear_i    = 1'b1;
        out_full_i = 1'b0;
        step();
        clear_i = 1'b0;

        // Asynchronous reset in the middle of a PUSH pulse
        in_valid = 1'b1;
        in_l = 24'h555555;
        in_r = 24'hAAAAAA;
        step();
        in_valid = 1'b0;
        step();
        chk("push_before_reset", 48'(out_write), 48'd1);
        #3;
        rstn_i = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_write", 48'(out_write), 48'd0);
        compare_model();
        @(posedge clk_i);
        #1;
        chk("rst_hold_write", 48'(out_write), 48'd0);
        compare_model();
        rstn_i = 1'b1;
        repeat (4) step();
        chk("post_rst_level", 48'(level_o), 48'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_frame_fifo.md
# audio_frame_fifo

Stereo frame buffer between the CPU-side audio registers in `wishbone_bus_logic` and the `i2s_master` write port. It absorbs bursts of software-written frames and feeds them to the I2S transmitter whenever the transmitter reports space. It exposes fill level, a low-water interrupt and a sticky overflow flag so firmware can refill by interrupt instead of polling `full`.

## Interface
- `DEPTH`, 16: frame entries; power of two, 4..256.
- `SAMPLE_W`, 24: bits per channel sample.
- `LOW_WATER`, 4: `low_irq_o` threshold in frames; 0..DEPTH-1.

- `clk_i` in 1: SoC clock (clk_soc domain); all logic rising edge.
- `rstn_i` in 1: asynchronous, active-low reset.
- `in_l` in SAMPLE_W: left sample from bus logic.
- `in_r` in SAMPLE_W: right sample from bus logic.
- `in_valid` in 1: one-cycle write strobe for {in_l,in_r}.
- `in_full` out 1: FIFO holds DEPTH frames; replaces adau_audio_full at the bus logic.
- `clear_i` in 1: synchronous flush.
- `out_l` out SAMPLE_W: left sample to i2s_master frame_in_l.
- `out_r` out SAMPLE_W: right sample to i2s_master frame_in_r.
- `out_write` out 1: one-cycle strobe to i2s_master write_frame.
- `out_full_i` in 1: i2s_master full.
- `level_o` out log2(DEPTH)+1: current frame count, 0..DEPTH.
- `low_irq_o` out 1: level_o <= LOW_WATER.
- `overflow_o` out 1: sticky; a write was dropped while full.

## Operation
- Storage: DEPTH x 2*SAMPLE_W. Entries are {l,r}. Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits.
- Write: accepted at an edge when in_valid=1 and count<DEPTH, using the count before that edge.
- Write when count=DEPTH: the frame is dropped and overflow_o is set. No pointer or count change.
- Pop in the same cycle as a full write does not make room for that write; the write is still dropped.
- Drain FSM, states IDLE, PUSH, HOLD:
  - IDLE -> PUSH when count>0 and out_full_i=0. The head entry is loaded into out_l/out_r, the read pointer advances and count decrements on that edge.
  - PUSH: out_write=1 for exactly this cycle. Then -> HOLD unconditionally.
  - HOLD: one cycle in which out_full_i is ignored, covering the i2s_master full update latency. Then -> IDLE.
- Simultaneous accepted write and pop: count unchanged; both pointers advance.
- out_l/out_r keep the last popped frame until the next pop.
- clear_i (priority over all else): pointers and count go to 0, overflow_o goes to 0 and the FSM goes to IDLE.
  - out_write is forced 0 in the cycle after clear_i, even if the FSM was entering PUSH.
  - A write in the same cycle as clear_i is discarded and does not set overflow.
  - out_l/out_r are not cleared.
- Status outputs:
  - in_full = (count==DEPTH).
  - level_o = count.
  - low_irq_o = (count<=LOW_WATER).
  - All three are decoded from the count register, so they change on the edge that updates count.

## Timing
- Reset values:
  - out_write 0, out_l 0, out_r 0.
  - level_o 0, in_full 0, overflow_o 0.
  - low_irq_o 1.
  - FSM IDLE, pointers 0.
- Write latency: in_valid sampled at edge t -> level_o incremented after t.
- Empty-to-output latency: with out_full_i=0 throughout, out_write is high in the cycle after edge t+1, so it is 2 cycles from the strobe.
- Maximum drain rate: 1 frame per 3 cycles (PUSH, HOLD, IDLE). This exceeds the 48 kHz need by orders of magnitude.
- out_full_i is sampled only in IDLE. A rise during PUSH or HOLD does not cancel the pulse already issued.
- Reset asserted mid-operation: all state goes to reset values asynchronously. A half-issued pulse is cut off immediately.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_W` constant.
  - `audio_frame_t` struct {l,r}.
  - `drain_state_t` enum {IDLE, PUSH, HOLD}.
  - i2s_master and the bus logic reuse the same package.
- Sub-module `audio_fifo_mem`: synchronous-write, registered-read RAM, DEPTH x 2*SAMPLE_W. It infers LUTRAM/BRAM and contains no control logic.
- Top holds the pointers, count, FSM and flags.

## Test plan
- Reset, then one write {l=0x123456, r=0xABCDEF} with out_full_i=0:
  - level_o goes 0->1->0.
  - out_write pulses once, 2 cycles after in_valid, with out_l=0x123456, out_r=0xABCDEF.
- out_full_i=1, 16 writes then a 17th:
  - in_full=1 after the 16th write; the 17th sets overflow_o=1; level_o stays 16.
  - Releasing out_full_i drains the frames in order, one pulse per 3 cycles.
- Write and pop in the same cycle at level 5: level_o stays 5; data order is preserved across pointer wrap (run 40 frames).
- Level sweep with LOW_WATER=4: low_irq_o=1 at level 4 and 0 at level 5, toggling exactly on the count edge.
- clear_i on the cycle the FSM enters PUSH, with level 8 and overflow set:
  - no out_write pulse;
  - level_o=0, overflow_o=0, low_irq_o=1 next cycle.
- rstn_i asserted low during PUSH: out_write drops immediately; all outputs hold their reset values until release.
